// File: rtl/stereo_pkg.sv
// Shared types and constants for the stereo capture path.
// Holds the frame writer FSM encoding, byte-enable codes and FIFO entry sizing.
package stereo_pkg;

    typedef enum logic [1:0] {
        FW_EMPTY = 2'd0,
        FW_HALF  = 2'd1,
        FW_DRAIN = 2'd2
    } fw_state_e;

    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_BOTH = 2'b11;

    localparam int unsigned FW_ADDR_W = 19;

    // FIFO entry is {word address, data, byte enables}
    function automatic int unsigned fw_entry_w(input int unsigned addr_w);
        return addr_w - 1 + 16 + 2;
    endfunction

    localparam int unsigned FW_ENTRY_W = FW_ADDR_W - 1 + 16 + 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO; the head is zero while empty.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push, do_pop;

    always_comb begin
        empty_o = (cnt_q == '0);
        full_o  = (cnt_q == CntW'(DEPTH));
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/frame_writer.sv
// Packs camera pixels two per 16-bit SRAM word, buffers them and drains over req/ack.
// On a vsync fall the pending half word is flushed and frame_done fires once drained.
module frame_writer
    import stereo_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 19
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              is_val,
    input  logic [7:0]        value,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              vsync,
    output logic              wr_req,
    input  logic              wr_ack,
    output logic [ADDR_W-2:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic [1:0]        wr_be,
    output logic              frame_done,
    output logic              overflow,
    output logic [15:0]       drop_count
);

    localparam int unsigned WA     = ADDR_W - 1;
    localparam int unsigned EntryW = fw_entry_w(ADDR_W);

    fw_state_e         state_q, state_d;
    logic [7:0]        byte_q, byte_d;
    logic [WA-1:0]     waddr_q, waddr_d;
    logic              skid_vld_q, skid_vld_d;
    logic [EntryW-1:0] skid_q, skid_d;
    logic              vsync_q;
    logic              overflow_q;
    logic [15:0]       drop_q;

    logic [WA-1:0]     pix_waddr;
    logic              pix_odd, vsync_fall, pend;
    logic [3:0]        src_vld;
    logic [EntryW-1:0] src [4];
    logic              c0_vld, c1_vld;
    logic [EntryW-1:0] c0, c1;
    logic              fifo_full, fifo_empty, pop, drop;
    logic [EntryW-1:0] fifo_rdata;

    assign pix_waddr  = mem_addr[ADDR_W-1:1];
    assign pix_odd    = mem_addr[0];
    assign vsync_fall = vsync_q && !vsync;

    // Word sources in age order: skid, pixel-completed words, flushed half word
    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        waddr_d    = waddr_q;
        pend       = (state_q == FW_HALF);
        frame_done = 1'b0;
        src_vld    = '0;
        for (int i = 0; i < 4; i++) src[i] = '0;
        src_vld[0] = skid_vld_q;
        src[0]     = skid_q;

        if (state_q == FW_DRAIN) begin
            if (fifo_empty && !skid_vld_q) begin
                state_d    = FW_EMPTY;
                frame_done = 1'b1;
            end
        end else begin
            if (is_val) begin
                if (pend && pix_odd && (pix_waddr == waddr_q)) begin
                    src_vld[1] = 1'b1;
                    src[1]     = {waddr_q, value, byte_q, BE_BOTH};
                    pend       = 1'b0;
                end else begin
                    if (pend) begin
                        src_vld[1] = 1'b1;
                        src[1]     = {waddr_q, 8'h00, byte_q, BE_LO};
                        pend       = 1'b0;
                    end
                    if (pix_odd) begin
                        src_vld[2] = 1'b1;
                        src[2]     = {pix_waddr, value, 8'h00, BE_HI};
                    end else begin
                        pend    = 1'b1;
                        byte_d  = value;
                        waddr_d = pix_waddr;
                    end
                end
            end
            if (vsync_fall) begin
                if (pend) begin
                    src_vld[3] = 1'b1;
                    src[3]     = {waddr_d, 8'h00, byte_d, BE_LO};
                end
                state_d = FW_DRAIN;
            end else begin
                state_d = pend ? FW_HALF : FW_EMPTY;
            end
        end
    end

    // At most two sources are live; the older goes to the FIFO, the younger to the skid
    always_comb begin
        c0_vld = 1'b0;
        c1_vld = 1'b0;
        c0     = '0;
        c1     = '0;
        for (int i = 0; i < 4; i++) begin
            if (src_vld[i]) begin
                if (!c0_vld) begin
                    c0     = src[i];
                    c0_vld = 1'b1;
                end else begin
                    c1     = src[i];
                    c1_vld = 1'b1;
                end
            end
        end
        skid_vld_d = c1_vld;
        skid_d     = c1;
        pop        = wr_req && wr_ack;
        drop       = c0_vld && fifo_full && !pop;
    end

    sync_fifo #(
        .WIDTH (EntryW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (pclk),
        .rst_i   (reset),
        .push_i  (c0_vld),
        .wdata_i (c0),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign wr_req                     = !fifo_empty;
    assign {wr_addr, wr_data, wr_be}  = fifo_rdata;
    assign overflow                   = overflow_q;
    assign drop_count                 = drop_q;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q    <= FW_EMPTY;
            byte_q     <= '0;
            waddr_q    <= '0;
            skid_vld_q <= 1'b0;
            skid_q     <= '0;
            vsync_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            waddr_q    <= waddr_d;
            skid_vld_q <= skid_vld_d;
            skid_q     <= skid_d;
            vsync_q    <= vsync;
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer: a vector table for packing and end of frame,
// plus hand sequences for overflow, full-with-pop and mid-frame reset.
module tb_frame_writer;

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic        is_val = 1'b0;
    logic [7:0]  value = '0;
    logic [18:0] mem_addr = '0;
    logic        vsync = 1'b1;
    logic        wr_ack = 1'b0;
    logic        wr_req;
    logic [17:0] wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        frame_done;
    logic        overflow;
    logic [15:0] drop_count;

    int n_pass = 0;
    int n_total = 0;

    frame_writer #(
        .DEPTH  (4),
        .ADDR_W (19)
    ) dut (
        .pclk       (pclk),
        .reset      (reset),
        .is_val     (is_val),
        .value      (value),
        .mem_addr   (mem_addr),
        .vsync      (vsync),
        .wr_req     (wr_req),
        .wr_ack     (wr_ack),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .frame_done (frame_done),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        val;
        logic [7:0]  pix;
        logic [18:0] addr;
        logic        vs;
        logic        ack;
        logic        req;
        logic [17:0] waddr;
        logic [15:0] data;
        logic [1:0]  be;
        logic        done;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [7:0] p, input logic [18:0] a,
                                input logic vs, input logic ack, input logic req,
                                input logic [17:0] wa, input logic [15:0] d,
                                input logic [1:0] be, input logic done);
        vec_t r;
        r.val = v; r.pix = p; r.addr = a; r.vs = vs; r.ack = ack;
        r.req = req; r.waddr = wa; r.data = d; r.be = be; r.done = done;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step(input logic v, input logic [7:0] p, input logic [18:0] a,
                        input logic vs, input logic ack);
        is_val   = v;
        value    = p;
        mem_addr = a;
        vsync    = vs;
        wr_ack   = ack;
        @(posedge pclk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic req, input logic [17:0] wa,
                              input logic [15:0] d, input logic [1:0] be);
        check({tag, ".wr_req"}, 32'(wr_req), 32'(req));
        check({tag, ".wr_addr"}, 32'(wr_addr), 32'(wa));
        check({tag, ".wr_data"}, 32'(wr_data), 32'(d));
        check({tag, ".wr_be"}, 32'(wr_be), 32'(be));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_head(tag, 1'b0, '0, '0, '0);
        check({tag, ".frame_done"}, 32'(frame_done), 32'd0);
        check({tag, ".overflow"}, 32'(overflow), 32'd0);
        check({tag, ".drop_count"}, 32'(drop_count), 32'd0);
    endtask

    vec_t tbl [18];

    initial begin
        // Packing, line break, skid, end of frame with flush and drain
        tbl[0]  = mk(1, 8'h11, 19'd0,  1, 1, 0, 18'd0,  16'h0000, 2'b00, 0);
        tbl[1]  = mk(1, 8'h22, 19'd1,  1, 1, 1, 18'd0,  16'h2211, 2'b11, 0);
        tbl[2]  = mk(1, 8'h33, 19'd2,  1, 1, 0, 18'd0,  16'h0000, 2'b00, 0);
        tbl[3]  = mk(1, 8'h44, 19'd3,  1, 1, 1, 18'd1,  16'h4433, 2'b11, 0);
        tbl[4]  = mk(0, 8'h00, 19'd0,  1, 1, 0, 18'd0,  16'h0000, 2'b00, 0);
        tbl[5]  = mk(1, 8'hAA, 19'd10, 1, 0, 0, 18'd0,  16'h0000, 2'b00, 0);
        tbl[6]  = mk(1, 8'hBB, 19'd20, 1, 0, 1, 18'd5,  16'h00AA, 2'b01, 0);
        tbl[7]  = mk(0, 8'h00, 19'd0,  1, 0, 1, 18'd5,  16'h00AA, 2'b01, 0);
        tbl[8]  = mk(0, 8'h00, 19'd0,  1, 1, 0, 18'd0,  16'h0000, 2'b00, 0);
        tbl[9]  = mk(1, 8'h5C, 19'd7,  1, 0, 1, 18'd10, 16'h00BB, 2'b01, 0);
        tbl[10] = mk(0, 8'h00, 19'd0,  1, 1, 1, 18'd3,  16'h5C00, 2'b10, 0);
        tbl[11] = mk(0, 8'h00, 19'd0,  1, 1, 0, 18'd0,  16'h0000, 2'b00, 0);
        tbl[12] = mk(1, 8'h66, 19'd8,  1, 1, 0, 18'd0,  16'h0000, 2'b00, 0);
        tbl[13] = mk(0, 8'h00, 19'd0,  0, 0, 1, 18'd4,  16'h0066, 2'b01, 0);
        tbl[14] = mk(1, 8'h77, 19'd9,  0, 0, 1, 18'd4,  16'h0066, 2'b01, 0);
        tbl[15] = mk(0, 8'h00, 19'd0,  0, 1, 0, 18'd0,  16'h0000, 2'b00, 1);
        tbl[16] = mk(0, 8'h00, 19'd0,  0, 1, 0, 18'd0,  16'h0000, 2'b00, 0);
        tbl[17] = mk(0, 8'h00, 19'd0,  1, 1, 0, 18'd0,  16'h0000, 2'b00, 0);

        @(posedge pclk);
        @(posedge pclk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].val, tbl[i].pix, tbl[i].addr, tbl[i].vs, tbl[i].ack);
            check_head($sformatf("vec%0d", i), tbl[i].req, tbl[i].waddr, tbl[i].data, tbl[i].be);
            check($sformatf("vec%0d.frame_done", i), 32'(frame_done), 32'(tbl[i].done));
        end
        check("frame.overflow", 32'(overflow), 32'd0);

        // Backpressure: DEPTH+2 words with wr_ack low, last two dropped
        for (int i = 0; i < 6; i++) begin
            step(1, 8'(8'h80 + i), 19'(2 * i + 1), 1, 0);
            if (i == 3) begin
                check("bp.full.overflow", 32'(overflow), 32'd0);
                check("bp.full.drop_count", 32'(drop_count), 32'd0);
            end
        end
        check("bp.overflow", 32'(overflow), 32'd1);
        check("bp.drop_count", 32'(drop_count), 32'd2);
        for (int k = 0; k < 4; k++) begin
            check_head($sformatf("bp.drain%0d", k), 1'b1, 18'(k), {8'(8'h80 + k), 8'h00}, 2'b10);
            step(0, 8'h00, 19'd0, 1, 1);
        end
        check("bp.empty.wr_req", 32'(wr_req), 32'd0);

        // Full FIFO with a push and pop in the same cycle
        for (int i = 0; i < 4; i++) step(1, 8'(8'h40 + i), 19'(21 + 2 * i), 1, 0);
        check_head("fp.full", 1'b1, 18'd10, 16'h4000, 2'b10);
        step(1, 8'h44, 19'd29, 1, 1);
        check("fp.drop_count", 32'(drop_count), 32'd2);
        check("fp.overflow", 32'(overflow), 32'd1);
        for (int k = 1; k < 5; k++) begin
            check_head($sformatf("fp.drain%0d", k), 1'b1, 18'(10 + k),
                       {8'(8'h40 + k), 8'h00}, 2'b10);
            step(0, 8'h00, 19'd0, 1, 1);
        end
        check("fp.empty.wr_req", 32'(wr_req), 32'd0);

        // Reset with three words queued and a half word pending
        for (int i = 0; i < 3; i++) step(1, 8'(8'h50 + i), 19'(31 + 2 * i), 1, 0);
        step(1, 8'h60, 19'd40, 1, 0);
        check_head("rst.pre", 1'b1, 18'd15, 16'h5000, 2'b10);
        step(0, 8'h00, 19'd0, 1, 0);
        #3;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst.async");
        @(posedge pclk);
        #1;
        reset = 1'b0;
        step(1, 8'h99, 19'd41, 1, 0);
        check_head("rst.post", 1'b1, 18'd20, 16'h9900, 2'b10);
        step(0, 8'h00, 19'd0, 1, 1);
        check("rst.post.drained", 32'(wr_req), 32'd0);
        step(0, 8'h00, 19'd0, 1, 1);
        check("rst.post.no_stale", 32'(wr_req), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
